stream_downsize: RTL and testbench

Wide-to-narrow stream serializer that sits directly downstream of `stream_upsize`. It accepts one wide word of `T_DATA_RATIO` lanes plus a per-lane keep mask and a packet-end flag. It emits the kept lanes one narrow beat at a time, lowest lane index first, and marks the final kept lane of a last word with `m_last_o`. Both sides use valid/ready handshakes. Full throughput is sustained: a word with K kept lanes occupies exactly K output cycles, with no bubble between words.

---
 rtl/stream_downsize.sv | 73 +++++++
 tb/tb_stream_downsize.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream serializer: buffers one wide word and emits its kept lanes,
// lowest index first, one narrow beat per cycle with no bubble between words.
module stream_downsize #(
    parameter int T_DATA_WIDTH = 4,
    parameter int T_DATA_RATIO = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO-1:0],
    input  logic [T_DATA_RATIO-1:0] s_keep_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);

    localparam int SEL_W = (T_DATA_RATIO > 1) ? $clog2(T_DATA_RATIO) : 1;
    localparam logic [T_DATA_RATIO-1:0] LANE_ONE = T_DATA_RATIO'(1);

    logic [T_DATA_WIDTH-1:0] buf_data [T_DATA_RATIO-1:0];
    logic                    buf_last;
    logic [T_DATA_RATIO-1:0] rem;
    logic [T_DATA_RATIO-1:0] rem_cleared;
    logic [SEL_W-1:0]        sel;
    logic                    busy;
    logic                    one_left;
    logic                    out_fire;
    logic                    in_fire;

    // Lowest set bit of rem wins; an empty mask falls back to lane 0.
    always_comb begin
        sel = '0;
        for (int i = T_DATA_RATIO - 1; i >= 0; i--) begin
            if (rem[i]) begin
                sel = SEL_W'(i);
            end
        end
    end

    // rem & (rem - 1) drops the lowest set bit: the mask after this beat drains.
    assign rem_cleared = rem & (rem - LANE_ONE);
    assign busy        = |rem;
    assign one_left    = busy && (rem_cleared == '0);
    assign out_fire    = busy && m_ready_i;

    assign m_valid_o = busy;
    assign m_last_o  = buf_last && one_left;
    assign m_data_o  = buf_data[sel];

    // Refill on the same edge as the final beat drains, so words stream back to back.
    assign s_ready_o = !busy || (out_fire && one_left);
    assign in_fire   = s_valid_i && s_ready_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            buf_last <= 1'b0;
            // NOTE: the data buffer is reset too, so m_data_o reads zero while idle after reset.
            buf_data <= '{default: '0};
        end else if (in_fire) begin
            // NOTE: a load overrides the final-lane clear; rem takes the new keep mask.
            buf_data <= s_data_i;
            buf_last <= s_last_i;
            rem      <= s_keep_i;
        end else if (out_fire) begin
            rem <= rem_cleared;
        end
    end

endmodule

// File: tb/tb_stream_downsize.sv
// Directed bench for stream_downsize (WIDTH 4, RATIO 2): latency, streaming,
// backpressure, sparse/empty keep and asynchronous reset mid-word.
module tb_stream_downsize;

    logic       clk;
    logic       rst_n;
    logic [3:0] s_data [1:0];
    logic [1:0] s_keep;
    logic       s_last;
    logic       s_valid;
    logic       s_ready;
    logic [3:0] m_data;
    logic       m_last;
    logic       m_valid;
    logic       m_ready;

    int n_tests = 0;
    int n_fail  = 0;
    logic acc;

    stream_downsize #(.T_DATA_WIDTH(4), .T_DATA_RATIO(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data_i  (s_data),
        .s_keep_i  (s_keep),
        .s_last_i  (s_last),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .m_data_o  (m_data),
        .m_last_o  (m_last),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records whether the word presented this cycle is accepted, then moves 2 ns past the edge.
    task automatic tick();
        acc = s_valid && s_ready;
        @(posedge clk);
        #2;
    endtask

    task automatic set_word(input logic [3:0] d0, input logic [3:0] d1,
                            input logic [1:0] keep, input logic last, input logic valid);
        s_data[0] = d0;
        s_data[1] = d1;
        s_keep    = keep;
        s_last    = last;
        s_valid   = valid;
    endtask

    // Observed bundle: {m_valid, m_last, s_ready, m_data}.
    task automatic test_reset();
        rst_n   = 1'b0;
        m_ready = 1'b1;
        set_word(4'h0, 4'h0, 2'b00, 1'b0, 1'b0);
        #3;
        n_tests++;
        if ({m_valid, m_last, s_ready, m_data} !== {1'b0, 1'b0, 1'b1, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got v%b l%b r%b d%h want v0 l0 r1 d0", m_valid, m_last, s_ready, m_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_tests++;
        if ({m_valid, s_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_release_idle: got v%b r%b want v0 r1", m_valid, s_ready);
        end
    endtask

    task automatic test_full_word();
        set_word(4'h1, 4'h2, 2'b11, 1'b0, 1'b1);
        tick();
        s_valid = 1'b0;
        #1;
        n_tests++;
        if ({m_valid, m_last, s_ready, m_data} !== {1'b1, 1'b0, 1'b0, 4'h1}) begin
            n_fail++;
            $display("FAIL full_beat0: got v%b l%b r%b d%h want v1 l0 r0 d1", m_valid, m_last, s_ready, m_data);
        end
        tick();
        #1;
        n_tests++;
        if ({m_valid, m_last, s_ready, m_data} !== {1'b1, 1'b0, 1'b1, 4'h2}) begin
            n_fail++;
            $display("FAIL full_beat1: got v%b l%b r%b d%h want v1 l0 r1 d2", m_valid, m_last, s_ready, m_data);
        end
        tick();
        #1;
        n_tests++;
        if ({m_valid, s_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL full_idle: got v%b r%b want v0 r1", m_valid, s_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] w_d0   [3] = '{4'h0, 4'h2, 4'hA};
        logic [3:0] w_d1   [3] = '{4'h1, 4'h0, 4'hB};
        logic [1:0] w_keep [3] = '{2'b11, 2'b01, 2'b11};
        logic       w_last [3] = '{1'b0, 1'b1, 1'b1};
        logic [3:0] e_data [5] = '{4'h0, 4'h1, 4'h2, 4'hA, 4'hB};
        logic       e_last [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic       e_rdy  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int idx = 0;
        set_word(w_d0[0], w_d1[0], w_keep[0], w_last[0], 1'b1);
        for (int c = 0; c < 5; c++) begin
            tick();
            if (acc) idx++;
            if (idx < 3) set_word(w_d0[idx], w_d1[idx], w_keep[idx], w_last[idx], 1'b1);
            else s_valid = 1'b0;
            #1;
            n_tests++;
            if ({m_valid, m_last, s_ready, m_data} !== {1'b1, e_last[c], e_rdy[c], e_data[c]}) begin
                n_fail++;
                $display("FAIL b2b_beat%0d: got v%b l%b r%b d%h want v1 l%b r%b d%h",
                         c, m_valid, m_last, s_ready, m_data, e_last[c], e_rdy[c], e_data[c]);
            end
        end
        tick();
        #1;
        n_tests++;
        if ({m_valid, s_ready} !== 2'b01 || idx != 3) begin
            n_fail++;
            $display("FAIL b2b_idle: got v%b r%b words %0d want v0 r1 words 3", m_valid, s_ready, idx);
        end
    endtask

    task automatic test_single_lane();
        logic [3:0] w_d0   [3] = '{4'h3, 4'h0, 4'h5};
        logic [3:0] w_d1   [3] = '{4'h0, 4'h4, 4'h0};
        logic [1:0] w_keep [3] = '{2'b01, 2'b10, 2'b01};
        logic       w_last [3] = '{1'b0, 1'b0, 1'b1};
        logic [3:0] e_data [3] = '{4'h3, 4'h4, 4'h5};
        int idx = 0;
        set_word(w_d0[0], w_d1[0], w_keep[0], w_last[0], 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick();
            if (acc) idx++;
            if (idx < 3) set_word(w_d0[idx], w_d1[idx], w_keep[idx], w_last[idx], 1'b1);
            else s_valid = 1'b0;
            #1;
            n_tests++;
            if ({m_valid, m_last, s_ready, m_data} !== {1'b1, c == 2, 1'b1, e_data[c]}) begin
                n_fail++;
                $display("FAIL single_beat%0d: got v%b l%b r%b d%h want v1 l%b r1 d%h",
                         c, m_valid, m_last, s_ready, m_data, c == 2, e_data[c]);
            end
        end
        tick();
        #1;
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: got v%b want v0", m_valid);
        end
    endtask

    task automatic test_backpressure();
        set_word(4'hA, 4'hB, 2'b11, 1'b1, 1'b1);
        tick();
        s_valid = 1'b0;
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++;
            if ({m_valid, m_last, s_ready, m_data} !== {1'b1, 1'b0, 1'b0, 4'hA}) begin
                n_fail++;
                $display("FAIL stall_cycle%0d: got v%b l%b r%b d%h want v1 l0 r0 dA", k, m_valid, m_last, s_ready, m_data);
            end
            tick();
        end
        m_ready = 1'b1;
        #1;
        n_tests++;
        if ({m_valid, s_ready, m_data} !== {1'b1, 1'b0, 4'hA}) begin
            n_fail++;
            $display("FAIL stall_release: got v%b r%b d%h want v1 r0 dA", m_valid, s_ready, m_data);
        end
        tick();
        #1;
        n_tests++;
        if ({m_valid, m_last, s_ready, m_data} !== {1'b1, 1'b1, 1'b1, 4'hB}) begin
            n_fail++;
            $display("FAIL stall_next: got v%b l%b r%b d%h want v1 l1 r1 dB", m_valid, m_last, s_ready, m_data);
        end
        tick();
    endtask

    task automatic test_sparse_empty();
        set_word(4'h5, 4'hB, 2'b10, 1'b1, 1'b1);
        tick();
        s_valid = 1'b0;
        #1;
        n_tests++;
        if ({m_valid, m_last, s_ready, m_data} !== {1'b1, 1'b1, 1'b1, 4'hB}) begin
            n_fail++;
            $display("FAIL sparse_beat: got v%b l%b r%b d%h want v1 l1 r1 dB", m_valid, m_last, s_ready, m_data);
        end
        tick();
        set_word(4'h3, 4'h4, 2'b00, 1'b1, 1'b1);
        #1;
        n_tests++;
        if ({m_valid, s_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL empty_ready: got v%b r%b want v0 r1", m_valid, s_ready);
        end
        tick();
        s_valid = 1'b0;
        #1;
        n_tests++;
        if ({m_valid, m_last, s_ready, m_data} !== {1'b0, 1'b0, 1'b1, 4'h3}) begin
            n_fail++;
            $display("FAIL empty_no_beat: got v%b l%b r%b d%h want v0 l0 r1 d3", m_valid, m_last, s_ready, m_data);
        end
        tick();
    endtask

    task automatic test_reset_mid_word();
        set_word(4'h1, 4'h2, 2'b11, 1'b0, 1'b1);
        tick();
        s_valid = 1'b0;
        m_ready = 1'b0;
        #1;
        n_tests++;
        if ({m_valid, m_data} !== {1'b1, 4'h1}) begin
            n_fail++;
            $display("FAIL rstmid_pre: got v%b d%h want v1 d1", m_valid, m_data);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({m_valid, m_last, s_ready, m_data} !== {1'b0, 1'b0, 1'b1, 4'h0}) begin
            n_fail++;
            $display("FAIL rstmid_async: got v%b l%b r%b d%h want v0 l0 r1 d0", m_valid, m_last, s_ready, m_data);
        end
        tick();
        rst_n   = 1'b1;
        m_ready = 1'b1;
        tick();
        #1;
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_no_stale: got v%b d%h want v0", m_valid, m_data);
        end
        set_word(4'h7, 4'h8, 2'b11, 1'b1, 1'b1);
        tick();
        s_valid = 1'b0;
        #1;
        n_tests++;
        if ({m_valid, m_last, m_data} !== {1'b1, 1'b0, 4'h7}) begin
            n_fail++;
            $display("FAIL rstmid_next0: got v%b l%b d%h want v1 l0 d7", m_valid, m_last, m_data);
        end
        tick();
        #1;
        n_tests++;
        if ({m_valid, m_last, m_data} !== {1'b1, 1'b1, 4'h8}) begin
            n_fail++;
            $display("FAIL rstmid_next1: got v%b l%b d%h want v1 l1 d8", m_valid, m_last, m_data);
        end
        tick();
    endtask

    initial begin
        acc = 1'b0;
        test_reset();
        test_full_word();
        test_back_to_back();
        test_single_lane();
        test_backpressure();
        test_sparse_empty();
        test_reset_mid_word();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
